// File: rtl/lc3_decode_stage_if.sv
// Decode-stage port bundle: fetch-side request (enable/instruction/NPC) plus the
// registered IR, NPC and control words handed to the execute stage.
interface lc3_decode_stage_if;
  logic        enable_decode;
  logic [15:0] dout;
  logic [15:0] npc_in;

  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;
  logic        decode_valid;
  logic        illegal_op;

  modport master (
    output enable_decode, dout, npc_in,
    input  IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op
  );

  modport slave (
    input  enable_decode, dout, npc_in,
    output IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op
  );
endinterface

// File: rtl/lc3_decode_stage.sv
// LC-3 decode stage: registers IR/NPC and the execute/writeback/memory control words.
// Latency 1 cycle; no backpressure -- enable_decode low simply holds state and drops decode_valid.
module lc3_decode_stage #(
  parameter int INSTR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  lc3_decode_stage_if.slave dec
);

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_e;

  typedef struct packed {
    logic [1:0] alu_control;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic       op2select;
  } e_ctrl_t;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NOT  = 2'b10;

  localparam logic [1:0] PC1_NONE = 2'b00;
  localparam logic [1:0] PC1_OFF9 = 2'b01;
  localparam logic [1:0] PC1_OFF6 = 2'b10;
  localparam logic [1:0] PC1_ZERO = 2'b11;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_LEA   = 2'b10;

  opcode_e             opcode;
  e_ctrl_t             dec_e;
  logic [1:0]          dec_w;
  logic                dec_mem;
  logic                dec_illegal;

  logic [INSTR_W-1:0]  ir_d,      ir_q;
  logic [INSTR_W-1:0]  npc_d,     npc_q;
  e_ctrl_t             e_ctrl_d,  e_ctrl_q;
  logic [1:0]          w_ctrl_d,  w_ctrl_q;
  logic                mem_ctrl_d, mem_ctrl_q;
  logic                valid_d,   valid_q;
  logic                illegal_d, illegal_q;

  assign opcode = opcode_e'(dec.dout[15:12]);

  // Pure instruction decode; illegal opcodes fall through with all control words zero.
  always_comb begin
    dec_e       = '0;
    dec_w       = WB_ALU;
    dec_mem     = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OP_ADD: begin
        dec_e.alu_control = ALU_ADD;
        dec_e.op2select   = ~dec.dout[5];
      end
      OP_AND: begin
        dec_e.alu_control = ALU_AND;
        dec_e.op2select   = ~dec.dout[5];
      end
      OP_NOT: begin
        dec_e.alu_control = ALU_NOT;
      end
      OP_BR, OP_ST: begin
        dec_e.pcselect1 = PC1_OFF9;
        dec_e.pcselect2 = 1'b1;
      end
      OP_LD: begin
        dec_e.pcselect1 = PC1_OFF9;
        dec_e.pcselect2 = 1'b1;
        dec_w           = WB_MEM;
      end
      OP_LDI: begin
        dec_e.pcselect1 = PC1_OFF9;
        dec_e.pcselect2 = 1'b1;
        dec_w           = WB_MEM;
        dec_mem         = 1'b1;
      end
      OP_STI: begin
        dec_e.pcselect1 = PC1_OFF9;
        dec_e.pcselect2 = 1'b1;
        dec_mem         = 1'b1;
      end
      OP_LEA: begin
        dec_e.pcselect1 = PC1_OFF9;
        dec_e.pcselect2 = 1'b1;
        dec_w           = WB_LEA;
      end
      OP_LDR: begin
        dec_e.pcselect1 = PC1_OFF6;
        dec_w           = WB_MEM;
      end
      OP_STR: begin
        dec_e.pcselect1 = PC1_OFF6;
      end
      OP_JMP: begin
        dec_e.pcselect1 = PC1_ZERO;
      end
      OP_JSR, OP_RTI, OP_RES, OP_TRAP: begin
        dec_illegal = 1'b1;
      end
      default: begin
        dec_e.pcselect1 = PC1_NONE;
      end
    endcase
  end

  // The decode result is only selected under a known enable, so junk on dout while idle never lands.
  always_comb begin
    ir_d       = ir_q;
    npc_d      = npc_q;
    e_ctrl_d   = e_ctrl_q;
    w_ctrl_d   = w_ctrl_q;
    mem_ctrl_d = mem_ctrl_q;
    illegal_d  = illegal_q;
    valid_d    = 1'b0;
    if (dec.enable_decode) begin
      ir_d       = dec.dout;
      npc_d      = dec.npc_in;
      e_ctrl_d   = dec_e;
      w_ctrl_d   = dec_w;
      mem_ctrl_d = dec_mem;
      illegal_d  = dec_illegal;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_q       <= '0;
      npc_q      <= '0;
      e_ctrl_q   <= '0;
      w_ctrl_q   <= '0;
      mem_ctrl_q <= 1'b0;
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      npc_q      <= npc_d;
      e_ctrl_q   <= e_ctrl_d;
      w_ctrl_q   <= w_ctrl_d;
      mem_ctrl_q <= mem_ctrl_d;
      valid_q    <= valid_d;
      illegal_q  <= illegal_d;
    end
  end

  assign dec.IR           = ir_q;
  assign dec.npc_out      = npc_q;
  assign dec.E_Control    = e_ctrl_q;
  assign dec.W_Control    = w_ctrl_q;
  assign dec.Mem_Control  = mem_ctrl_q;
  assign dec.decode_valid = valid_q;
  assign dec.illegal_op   = illegal_q;

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Scoreboard bench for lc3_decode_stage: directed ISA cases, random traffic and async reset pulses.
module tb_lc3_decode_stage;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [5:0]  e;
    logic [1:0]  w;
    logic        mem;
    logic        valid;
    logic        illegal;
  } out_t;

  typedef struct {
    int   tag;
    out_t exp;
  } sb_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  lc3_decode_stage_if dif ();

  lc3_decode_stage #(.INSTR_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .dec   (dif.slave)
  );

  always #5 clock = ~clock;

  int   edge_cnt = 0;
  int   n_cmp    = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;
  sb_t  sbq[$];
  out_t model_state = '0;

  always @(posedge clock) edge_cnt++;

  // Reference decode written from the ISA tables: sets of opcodes per control field.
  function automatic out_t decode_ref(input logic [15:0] ins, input logic [15:0] npc);
    out_t       r;
    logic [3:0] op;
    logic [1:0] alu, pc1, wb;
    logic       pc2, op2, mem;
    op      = ins[15:12];
    r       = '0;
    r.ir    = ins;
    r.npc   = npc;
    r.valid = 1'b1;
    if (op inside {4'h4, 4'h8, 4'hD, 4'hF}) begin
      r.illegal = 1'b1;
      return r;
    end
    alu = (op == 4'h5) ? 2'd1 : (op == 4'h9) ? 2'd2 : 2'd0;
    if (op inside {4'h0, 4'h2, 4'hA, 4'h3, 4'hB, 4'hE}) pc1 = 2'd1;
    else if (op inside {4'h6, 4'h7})                    pc1 = 2'd2;
    else if (op == 4'hC)                                pc1 = 2'd3;
    else                                                pc1 = 2'd0;
    pc2 = (op inside {4'h0, 4'h2, 4'hA, 4'h3, 4'hB, 4'hE});
    op2 = (op inside {4'h1, 4'h5}) ? !ins[5] : 1'b0;
    if (op inside {4'h2, 4'h6, 4'hA}) wb = 2'd1;
    else if (op == 4'hE)              wb = 2'd2;
    else                              wb = 2'd0;
    mem   = (op inside {4'hA, 4'hB});
    r.e   = {alu, pc1, pc2, op2};
    r.w   = wb;
    r.mem = mem;
    return r;
  endfunction

  function automatic out_t sample_dut();
    out_t s;
    s = {dif.IR, dif.npc_out, dif.E_Control, dif.W_Control,
         dif.Mem_Control, dif.decode_valid, dif.illegal_op};
    return s;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got IR=%h npc=%h E=%b W=%b M=%b V=%b ILL=%b, want IR=%h npc=%h E=%b W=%b M=%b V=%b ILL=%b",
               name, $time, act.ir, act.npc, act.e, act.w, act.mem, act.valid, act.illegal,
               exp.ir, exp.npc, exp.e, exp.w, exp.mem, exp.valid, exp.illegal);
    end
  endtask

  // Drive one cycle after the active edge; expectation is tagged with the edge that will apply it.
  task automatic cycle(input logic en, input logic [15:0] d, input logic [15:0] n, input bit release_rst);
    sb_t  ent;
    out_t e;
    @(posedge clock);
    #1;
    if (release_rst) reset = 1'b0;
    dif.enable_decode = en;
    dif.dout          = en ? d : 16'hxxxx;
    dif.npc_in        = n;
    if (!reset) begin
      if (en) begin
        e = decode_ref(d, n);
      end else begin
        e       = model_state;
        e.valid = 1'b0;
      end
      model_state = e;
      ent.tag = edge_cnt + 1;
      ent.exp = e;
      sbq.push_back(ent);
    end
  endtask

  task automatic assert_reset_mid_cycle();
    #1;
    reset = 1'b1;
    sbq.delete();
    model_state = '0;
  endtask

  // Monitor: every falling edge compares the DUT against the expectation in force for that cycle.
  initial begin : monitor
    out_t cur;
    cur = '0;
    while (!done) begin
      @(negedge clock);
      if (done) break;
      if (reset) begin
        cur = '0;
        check("reset_zero", sample_dut(), cur);
      end else begin
        if (sbq.size() != 0 && sbq[0].tag <= edge_cnt) begin
          if (sbq[0].tag < edge_cnt) begin
            n_cmp++;
            n_fail++;
            $display("FAIL stale_entry: tag %0d at edge %0d", sbq[0].tag, edge_cnt);
          end
          cur = sbq.pop_front().exp;
          check(cur.valid ? "accept" : "hold", sample_dut(), cur);
        end else begin
          check("idle_after_reset", sample_dut(), cur);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d queued, want 0", sbq.size());
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  logic [15:0] dir_ins [10] = '{16'h1283, 16'h0000, 16'h1262, 16'h997F, 16'h6285,
                                16'hB604, 16'hA204, 16'hF025, 16'h0000, 16'hE203};
  bit          dir_en  [10] = '{1, 0, 1, 1, 1, 1, 1, 1, 0, 1};

  initial begin : stimulus
    logic [15:0] npc;
    dif.enable_decode = 1'b1;
    dif.dout          = 16'h5020;
    dif.npc_in        = 16'h3001;

    // Reset held with a live request, then the first edge after release accepts it.
    cycle(1'b1, 16'h5020, 16'h3001, 1'b0);
    cycle(1'b1, 16'h5020, 16'h3001, 1'b0);
    cycle(1'b1, 16'h5020, 16'h3001, 1'b1);

    npc = 16'h3002;
    for (int i = 0; i < 10; i++) begin
      cycle(dir_en[i], dir_ins[i], npc, 1'b0);
      if (dir_en[i]) npc = npc + 16'd1;
    end
    cycle(1'b0, 16'h0000, 16'h0000, 1'b0);

    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom), 1'b0);
    end

    // Asynchronous reset pulse in the middle of a continuous burst.
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0);
    assert_reset_mid_cycle();
    cycle(1'b1, 16'h1283, 16'h4000, 1'b0);
    cycle(1'b1, 16'h1283, 16'h4000, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0);

    for (int i = 0; i < 100; i++) begin
      cycle(($urandom_range(0, 1) == 1), 16'($urandom), 16'($urandom), 1'b0);
    end
    cycle(1'b0, 16'h0000, 16'h0000, 1'b0);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b0);

    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    done = 1'b1;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
